// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code encodings and the execute-stage FSM states.
// ALU control decode imports the same package, so these encodings exist in one place only.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_SLL = 4'b0011,
      ALU_SRL = 4'b0100,
      ALU_SRA = 4'b0101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } alu_state_e;

   function automatic logic is_shift_op(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Operation/result handshake bundle between operand fetch, the execute ALU and writeback.
// Signal names are written from the ALU's point of view; the master modport is the upstream/downstream side.
interface alu_seq_exec_if #(
   parameter int XLEN = 32
);
   logic            op_valid_i;
   logic            op_ready_o;
   logic [3:0]      alu_control_op_i;
   logic [XLEN-1:0] operand_a_i;
   logic [XLEN-1:0] operand_b_i;
   logic            res_valid_o;
   logic            res_ready_i;
   logic [XLEN-1:0] result_o;
   logic            zero_o;
   logic            err_o;

   modport master (
      output op_valid_i, alu_control_op_i, operand_a_i, operand_b_i, res_ready_i,
      input  op_ready_o, res_valid_o, result_o, zero_o, err_o
   );

   modport slave (
      input  op_valid_i, alu_control_op_i, operand_a_i, operand_b_i, res_ready_i,
      output op_ready_o, res_valid_o, result_o, zero_o, err_o
   );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations (AND/OR/ADD/SUB/SLT) and illegal-code detection.
// Shift codes are legal here but produce zero; the iterative shifter lives in the top level.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      code,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (code)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL, ALU_SRL, ALU_SRA: result = '0;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: one op per handshake, single-cycle logic/arith, bit-serial shifts.
// Holds the IDLE/SHIFT/DONE controller, the shift working register and the result registers.
module alu_seq_exec
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic         clk_i,
   input logic         rst_i,
   alu_seq_exec_if.slave bus
);

   localparam int SHAMT_W = $clog2(XLEN);

   alu_state_e         state_reg;
   logic [XLEN-1:0]    work_reg;
   logic [XLEN-1:0]    result_reg;
   logic [SHAMT_W-1:0] count_reg;
   logic [3:0]         shift_code_reg;
   logic               zero_reg;
   logic               err_reg;

   logic [XLEN-1:0]    core_result;
   logic               core_illegal;
   logic [XLEN-1:0]    issue_result;
   logic [XLEN-1:0]    shift_next;
   logic [SHAMT_W-1:0] shamt;
   logic               issue_shift;
   logic               accept;

   alu_comb_core #(.XLEN(XLEN)) u_core (
      .code    (bus.alu_control_op_i),
      .a       (bus.operand_a_i),
      .b       (bus.operand_b_i),
      .result  (core_result),
      .illegal (core_illegal)
   );

   assign shamt        = bus.operand_b_i[SHAMT_W-1:0];
   assign issue_shift  = is_shift_op(bus.alu_control_op_i);
   // A zero-distance shift completes immediately with operand A unchanged.
   assign issue_result = issue_shift ? bus.operand_a_i : core_result;

   // Combinational path from res_ready_i lets a new op issue while the previous result drains.
   assign bus.op_ready_o = (state_reg == IDLE) || ((state_reg == DONE) && bus.res_ready_i);
   assign accept         = bus.op_valid_i && bus.op_ready_o;

   // One-bit shift network: SLL pulls from the lower neighbour, SRL/SRA from the upper one.
   for (genvar gi = 0; gi < XLEN; gi++) begin : g_shift
      logic left_bit;
      logic right_bit;
      if (gi == 0) begin : g_lsb
         assign left_bit = 1'b0;
      end else begin : g_mid_l
         assign left_bit = work_reg[gi-1];
      end
      if (gi == XLEN-1) begin : g_msb
         assign right_bit = (shift_code_reg == ALU_SRA) ? work_reg[XLEN-1] : 1'b0;
      end else begin : g_mid_r
         assign right_bit = work_reg[gi+1];
      end
      assign shift_next[gi] = (shift_code_reg == ALU_SLL) ? left_bit : right_bit;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         work_reg       <= '0;
         count_reg      <= '0;
         shift_code_reg <= 4'b0000;
         result_reg     <= '0;
         zero_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  if (issue_shift && (shamt != '0)) begin
                     state_reg      <= SHIFT;
                     work_reg       <= bus.operand_a_i;
                     count_reg      <= shamt;
                     shift_code_reg <= bus.alu_control_op_i;
                  end else begin
                     state_reg  <= DONE;
                     result_reg <= issue_result;
                     zero_reg   <= (issue_result == '0);
                     err_reg    <= core_illegal;
                  end
               end else if ((state_reg == DONE) && bus.res_ready_i) begin
                  state_reg <= IDLE;
               end
            end
            SHIFT: begin
               work_reg  <= shift_next;
               count_reg <= count_reg - SHAMT_W'(1);
               if (count_reg == SHAMT_W'(1)) begin
                  state_reg  <= DONE;
                  result_reg <= shift_next;
                  zero_reg   <= (shift_next == '0);
                  err_reg    <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.res_valid_o = (state_reg == DONE);
   assign bus.result_o    = result_reg;
   assign bus.zero_o      = zero_reg;
   assign bus.err_o       = err_reg;

endmodule
